// File: rtl/edn_dist_pkg.sv
// rtl/edn_dist_pkg.sv - shared constants, entry type and LFSR step for the entropy distribution network
package edn_dist_pkg;

    localparam logic [31:0] LFSR_POLY       = 32'h8020_0003;
    localparam int          ENDPOINT_WORD_W = 32;
    localparam int          EDN_MAX_BUS_W   = 128;

    // Sized for the widest bus; narrower instances leave the upper data bits at zero.
    typedef struct packed {
        logic                     fips;
        logic [EDN_MAX_BUS_W-1:0] data;
    } edn_entry_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/edn_dist_fifo.sv
// rtl/edn_dist_fifo.sv - synchronous FIFO holding packed entropy entries
module edn_dist_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap without compare logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/edn_dist.sv
// rtl/edn_dist.sv - LFSR entropy source, word packer, FIFO and round-robin endpoint distribution
module edn_dist
    import edn_dist_pkg::*;
#(
    parameter int          NUM_EP     = 2,
    parameter int          BUS_WIDTH  = 32,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] LFSR_SEED  = 32'h0000_0001
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        enable_i,
    input  logic                        fips_i,
    input  logic                        seed_valid_i,
    input  logic [31:0]                 seed_i,
    input  logic [NUM_EP-1:0]           ep_req_i,
    output logic [NUM_EP-1:0]           ep_ack_o,
    output logic [NUM_EP-1:0]           ep_fips_o,
    output logic [NUM_EP*BUS_WIDTH-1:0] ep_bus_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_lvl_o
);

    localparam int WORDS   = BUS_WIDTH / ENDPOINT_WORD_W;
    localparam int CNT_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int RR_W    = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
    localparam int ENTRY_W = BUS_WIDTH + 1;

    logic [31:0]               lfsr_q;
    logic                      gen;
    logic                      last_word;
    logic [CNT_W-1:0]          pack_cnt_q;
    logic [BUS_WIDTH-1:0]      pack_data_q;
    logic                      pack_fips_q;
    logic [BUS_WIDTH-1:0]      fill_data;
    logic                      fill_fips;

    logic                      fifo_full;
    logic                      fifo_empty;
    logic [ENTRY_W-1:0]        fifo_rdata;
    edn_entry_t                pop_entry;
    logic                      unused_entry_bits;

    logic [NUM_EP-1:0]         eligible;
    logic [RR_W-1:0]           cand;
    logic                      grant_valid;
    logic [RR_W-1:0]           grant_idx;
    logic [RR_W-1:0]           rr_q;

    logic [NUM_EP-1:0]         ack_q;
    logic [NUM_EP-1:0]         fips_q;
    logic [NUM_EP*BUS_WIDTH-1:0] bus_q;

    // A seed load steals the cycle, so the old state is never emitted alongside it.
    assign gen       = enable_i & ~fifo_full & ~seed_valid_i;
    assign last_word = (pack_cnt_q == CNT_W'(WORDS - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= LFSR_SEED;
        end else if (seed_valid_i) begin
            lfsr_q <= (seed_i == '0) ? LFSR_SEED : seed_i;
        end else if (gen) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    always_comb begin
        fill_data = pack_data_q;
        fill_data[int'(pack_cnt_q) * ENDPOINT_WORD_W +: ENDPOINT_WORD_W] = lfsr_q;
        fill_fips = ((pack_cnt_q == '0) | pack_fips_q) & fips_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pack_cnt_q  <= '0;
            pack_data_q <= '0;
            pack_fips_q <= 1'b1;
        end else if (!enable_i) begin
            pack_cnt_q  <= '0;
            pack_data_q <= '0;
            pack_fips_q <= 1'b1;
        end else if (gen) begin
            pack_cnt_q  <= last_word ? '0 : pack_cnt_q + 1'b1;
            pack_data_q <= last_word ? '0 : fill_data;
            pack_fips_q <= fill_fips;
        end
    end

    edn_dist_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .clr   (~enable_i),
        .push  (gen & last_word),
        .wdata ({fill_fips, fill_data}),
        .pop   (grant_valid),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_lvl_o)
    );

    always_comb begin
        pop_entry                     = '0;
        pop_entry.fips                = fifo_rdata[BUS_WIDTH];
        pop_entry.data[BUS_WIDTH-1:0] = fifo_rdata[BUS_WIDTH-1:0];
    end

    // Upper entry bits are only populated when BUS_WIDTH is at its maximum.
    assign unused_entry_bits = ^pop_entry.data;

    // Walk downward so the closest eligible index above the pointer wins last.
    always_comb begin
        eligible    = ep_req_i & ~ack_q;
        cand        = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (enable_i && !fifo_empty) begin
            for (int i = NUM_EP - 1; i >= 0; i--) begin
                cand = RR_W'((int'(rr_q) + i) % NUM_EP);
                if (eligible[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
        end else if (grant_valid) begin
            rr_q <= (int'(grant_idx) == NUM_EP - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_q  <= '0;
            fips_q <= '0;
            bus_q  <= '0;
        end else begin
            ack_q  <= '0;
            fips_q <= '0;
            bus_q  <= '0;
            if (grant_valid) begin
                ack_q[grant_idx]  <= 1'b1;
                fips_q[grant_idx] <= pop_entry.fips;
                bus_q[int'(grant_idx) * BUS_WIDTH +: BUS_WIDTH] <= pop_entry.data[BUS_WIDTH-1:0];
            end
        end
    end

    assign ep_ack_o  = ack_q;
    assign ep_fips_o = fips_q;
    assign ep_bus_o  = bus_q;

endmodule

// File: tb/tb_edn_dist.sv
// tb/tb_edn_dist.sv - directed self-checking bench for edn_dist (3x32-bit and 2x64-bit instances)
module tb_edn_dist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        en_a, fips_a, sv_a;
    logic [31:0] seed_a;
    logic [2:0]  req_a, ack_a, efips_a;
    logic [95:0] bus_a;
    logic [2:0]  lvl_a;

    logic        en_b, fips_b, sv_b;
    logic [31:0] seed_b;
    logic [1:0]  req_b, ack_b, efips_b;
    logic [127:0] bus_b;
    logic [2:0]  lvl_b;

    int compared;
    int mismatched;

    // LFSR words from seed 1, worked out by hand from the polynomial.
    localparam logic [31:0] WSEQ [0:7] = '{
        32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001,
        32'hB02C_0003, 32'hD836_0002, 32'h6C1B_0001, 32'hB62D_8003
    };

    edn_dist #(
        .NUM_EP(3), .BUS_WIDTH(32), .FIFO_DEPTH(4), .LFSR_SEED(32'h0000_0001)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en_a), .fips_i(fips_a),
        .seed_valid_i(sv_a), .seed_i(seed_a), .ep_req_i(req_a),
        .ep_ack_o(ack_a), .ep_fips_o(efips_a), .ep_bus_o(bus_a), .fifo_lvl_o(lvl_a)
    );

    edn_dist #(
        .NUM_EP(2), .BUS_WIDTH(64), .FIFO_DEPTH(4), .LFSR_SEED(32'h0000_0001)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(en_b), .fips_i(fips_b),
        .seed_valid_i(sv_b), .seed_i(seed_b), .ep_req_i(req_b),
        .ep_ack_o(ack_b), .ep_fips_o(efips_b), .ep_bus_o(bus_b), .fifo_lvl_o(lvl_b)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        en_a = 0; fips_a = 0; sv_a = 0; seed_a = '0; req_a = '0;
        en_b = 0; fips_b = 0; sv_b = 0; seed_b = '0; req_b = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        compared++;
        if (ack_a !== 3'b0) begin mismatched++; $display("FAIL reset_ack_a: got %b want 000", ack_a); end
        compared++;
        if (bus_a !== 96'h0) begin mismatched++; $display("FAIL reset_bus_a: got %h want 0", bus_a); end
        compared++;
        if (efips_a !== 3'b0) begin mismatched++; $display("FAIL reset_fips_a: got %b want 000", efips_a); end
        compared++;
        if (lvl_a !== 3'd0) begin mismatched++; $display("FAIL reset_lvl_a: got %0d want 0", lvl_a); end
        compared++;
        if ({ack_b, efips_b, bus_b, lvl_b} !== '0) begin
            mismatched++; $display("FAIL reset_b: got ack %b fips %b lvl %0d want all zero", ack_b, efips_b, lvl_b);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sequence();
        int cyc;
        int k;
        do_reset();
        req_a = 3'b001; fips_a = 1'b1; en_a = 1'b1;
        cyc = 0;
        k = 0;
        while (k < 3 && cyc < 12) begin
            step();
            cyc++;
            if (ack_a !== 3'b000) begin
                if (k == 0) begin
                    compared++;
                    if (cyc !== 2) begin mismatched++; $display("FAIL seq_latency: got %0d cycles want 2", cyc); end
                end
                compared++;
                if (ack_a !== 3'b001) begin mismatched++; $display("FAIL seq_ack[%0d]: got %b want 001", k, ack_a); end
                compared++;
                if (bus_a !== {64'h0, WSEQ[k]}) begin
                    mismatched++; $display("FAIL seq_data[%0d]: got %h want %h", k, bus_a, {64'h0, WSEQ[k]});
                end
                compared++;
                if (efips_a !== 3'b001) begin mismatched++; $display("FAIL seq_fips[%0d]: got %b want 001", k, efips_a); end
                k++;
            end
        end
        compared++;
        if (k !== 3) begin mismatched++; $display("FAIL seq_timeout: got %0d acks want 3", k); end
        idle_inputs();
    endtask

    task automatic test_full_rr();
        int          g_ord [5] = '{0, 1, 2, 0, 1};
        logic [95:0] exp_bus;
        logic [2:0]  exp_ack;
        do_reset();
        en_a = 1'b1; fips_a = 1'b1;
        repeat (4) step();
        compared++;
        if (lvl_a !== 3'd4) begin mismatched++; $display("FAIL full_lvl: got %0d want 4", lvl_a); end
        step();
        step();
        compared++;
        if (lvl_a !== 3'd4 || ack_a !== 3'b0) begin
            mismatched++; $display("FAIL full_hold: got lvl %0d ack %b want lvl 4 ack 000", lvl_a, ack_a);
        end
        req_a = 3'b111;
        for (int j = 0; j < 5; j++) begin
            step();
            exp_ack = 3'b001 << g_ord[j];
            exp_bus = '0;
            exp_bus[g_ord[j]*32 +: 32] = WSEQ[j];
            compared++;
            if (ack_a !== exp_ack) begin mismatched++; $display("FAIL rr_ack[%0d]: got %b want %b", j, ack_a, exp_ack); end
            compared++;
            if (bus_a !== exp_bus || efips_a !== exp_ack) begin
                mismatched++; $display("FAIL rr_data[%0d]: got %h fips %b want %h fips %b", j, bus_a, efips_a, exp_bus, exp_ack);
            end
            if (j == 0) begin
                compared++;
                if (lvl_a !== 3'd3) begin mismatched++; $display("FAIL full_pop_lvl: got %0d want 3", lvl_a); end
            end
        end
        compared++;
        if (lvl_a !== 3'd3) begin mismatched++; $display("FAIL rr_lvl: got %0d want 3", lvl_a); end
        idle_inputs();
    endtask

    task automatic test_seed_disable();
        do_reset();
        en_a = 1'b1; sv_a = 1'b1; seed_a = 32'hDEAD_BEEF;
        step();
        compared++;
        if (lvl_a !== 3'd0) begin mismatched++; $display("FAIL seed_blocks_gen: got lvl %0d want 0", lvl_a); end
        seed_a = 32'h0;
        step();
        sv_a = 1'b0;
        repeat (3) step();
        compared++;
        if (lvl_a !== 3'd3) begin mismatched++; $display("FAIL seed_fill_lvl: got %0d want 3", lvl_a); end
        en_a = 1'b0; req_a = 3'b001;
        step();
        compared++;
        if (lvl_a !== 3'd0) begin mismatched++; $display("FAIL disable_lvl: got %0d want 0", lvl_a); end
        for (int j = 0; j < 3; j++) begin
            compared++;
            if (ack_a !== 3'b0) begin mismatched++; $display("FAIL disable_ack[%0d]: got %b want 000", j, ack_a); end
            step();
        end
        en_a = 1'b1;
        step();
        compared++;
        if (ack_a !== 3'b0) begin mismatched++; $display("FAIL reenable_early: got %b want 000", ack_a); end
        step();
        compared++;
        if (ack_a !== 3'b001 || bus_a !== {64'h0, WSEQ[3]}) begin
            mismatched++; $display("FAIL reenable_data: got ack %b bus %h want ack 001 bus %h", ack_a, bus_a, {64'h0, WSEQ[3]});
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        en_a = 1'b1; fips_a = 1'b1; req_a = 3'b111;
        step();
        step();
        compared++;
        if (ack_a !== 3'b001 || lvl_a !== 3'd1) begin
            mismatched++; $display("FAIL mid_pre: got ack %b lvl %0d want ack 001 lvl 1", ack_a, lvl_a);
        end
        #1 rst_n = 1'b0;
        #1;
        compared++;
        if (ack_a !== 3'b0 || bus_a !== 96'h0 || efips_a !== 3'b0 || lvl_a !== 3'd0) begin
            mismatched++; $display("FAIL mid_async_clear: got ack %b fips %b lvl %0d bus %h want all zero", ack_a, efips_a, lvl_a, bus_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        compared++;
        if (ack_a !== 3'b001 || bus_a !== {64'h0, WSEQ[0]}) begin
            mismatched++; $display("FAIL mid_restart: got ack %b bus %h want ack 001 bus %h", ack_a, bus_a, {64'h0, WSEQ[0]});
        end
        idle_inputs();
    endtask

    task automatic test_packing();
        int cyc;
        do_reset();
        en_b = 1'b1; req_b = 2'b01; fips_b = 1'b1;
        step();
        fips_b = 1'b0;
        step();
        compared++;
        if (lvl_b !== 3'd1 || ack_b !== 2'b00) begin
            mismatched++; $display("FAIL pack_push: got lvl %0d ack %b want lvl 1 ack 00", lvl_b, ack_b);
        end
        fips_b = 1'b1;
        step();
        compared++;
        if (ack_b !== 2'b01) begin mismatched++; $display("FAIL pack_latency: got ack %b want 01 at cycle 3", ack_b); end
        compared++;
        if (bus_b !== {64'h0, 64'h8020_0003_0000_0001}) begin
            mismatched++; $display("FAIL pack_data0: got %h want %h", bus_b, {64'h0, 64'h8020_0003_0000_0001});
        end
        compared++;
        if (efips_b !== 2'b00) begin mismatched++; $display("FAIL pack_fips0: got %b want 00", efips_b); end
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (ack_b === 2'b00 && cyc < 8);
        compared++;
        if (cyc !== 2) begin mismatched++; $display("FAIL pack_gap: got %0d cycles want 2", cyc); end
        compared++;
        if (ack_b !== 2'b01 || bus_b !== {64'h0, WSEQ[3], WSEQ[2]} || efips_b !== 2'b01) begin
            mismatched++; $display("FAIL pack_data1: got ack %b fips %b bus %h want ack 01 fips 01 bus %h",
                                   ack_b, efips_b, bus_b, {64'h0, WSEQ[3], WSEQ[2]});
        end
        idle_inputs();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        idle_inputs();
        test_reset();
        test_sequence();
        test_full_rr();
        test_seed_disable();
        test_reset_mid();
        test_packing();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/edn_dist.md
Name: edn_dist

Overview:
- Parametrised Entropy Distribution Network model.
- Replaces the fixed 32-bit single-endpoint dummy EDN.
- Generates pseudo-random words from a seedable 32-bit Galois LFSR and packs them to BUS_WIDTH.
- Buffers packed entries in a FIFO and serves NUM_EP endpoints via round-robin req/ack handshake.
- Sits at SoC top, feeding the core's RNG consumers (dummy-instruction insertion, BIST pattern seeding).

Parameters:
- NUM_EP, 2: number of endpoints (1..8).
- BUS_WIDTH, 32: endpoint data width; multiple of 32, max 128.
- FIFO_DEPTH, 4: buffered entries; power of 2, ≥2.
- LFSR_SEED, 32'h0000_0001: reset / zero-seed substitute; nonzero.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- enable_i  in  1  generation and distribution enable
- fips_i  in  1  FIPS-quality flag of the source
- seed_valid_i  in  1  load seed_i into LFSR
- seed_i  in  32  LFSR seed
- ep_req_i  in  NUM_EP  per-endpoint request; level, held until ack
- ep_ack_o  out  NUM_EP  per-endpoint ack; one-cycle pulse
- ep_fips_o  out  NUM_EP  fips of delivered entry
- ep_bus_o  out  NUM_EP*BUS_WIDTH  entropy; endpoint k at bits [k*BUS_WIDTH +: BUS_WIDTH]
- fifo_lvl_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: all outputs 0; LFSR=LFSR_SEED; packer empty; FIFO empty; rr pointer 0.
- LFSR step: next = (s>>1) ^ (s[0] ? 32'h8020_0003 : 0).
- Emitted word = current state; LFSR then steps.
- A word is generated in a cycle iff enable_i=1, FIFO not full, and seed_valid_i=0.
- seed_valid_i=1: LFSR <= (seed_i==0 ? LFSR_SEED : seed_i). No word is generated that cycle. Allowed with enable_i=0.
- Packer: WORDS=BUS_WIDTH/32. Words are filled LSW first.
- Entry fips = AND of fips_i sampled on each constituent word's cycle.
- The entry is pushed at the edge on which the last word is captured. For WORDS=1, every generated word is pushed directly.
- FIFO full blocks generation even if a pop occurs in the same cycle. Simultaneous push+pop when not full leaves the level unchanged.
- Arbitration (cycle t):
  - Eligible set = ep_req_i & ~ep_ack_o. Masking the endpoint acked this cycle prevents double grant.
  - If enable_i=1, FIFO non-empty and eligible set ≠0: grant the first eligible index searching from the rr pointer upward, modulo NUM_EP.
  - Pop the FIFO head; rr pointer <= grant+1 mod NUM_EP.
- Delivery (cycle t+1): ep_ack_o[g]=1, ep_bus_o slice g = popped data, ep_fips_o[g] = popped fips. All outputs are registered.
- Non-acked slices and fips bits drive 0.
- Latency from empty, WORDS=1: enable_i rises before edge 0 → push at edge 0 → grant in cycle 1 → ack in cycle 2. General first-ack latency = WORDS+1 cycles.
- enable_i=0:
  - No generation, no grants.
  - Packer and FIFO synchronously cleared each cycle; fifo_lvl_o=0 next cycle.
  - An ack already registered still presents.
  - Requests stay pending; LFSR state is retained.
- A request dropped before ack is legal; no ack is issued to it unless already granted.
- Reset assertion mid-operation clears everything asynchronously; in-flight acks are lost.

Decomposition:
- Package edn_dist_pkg holds:
  - LFSR_POLY = 32'h8020_0003.
  - ENDPOINT_WORD_W = 32.
  - Typedef edn_entry_t {fips, data[BUS_WIDTH-1:0]}, a parameterised packed struct via width constant.
  - Function lfsr_next().
- Sub-module edn_dist_fifo: synchronous FIFO with push/pop/full/empty/level, depth FIFO_DEPTH. Instantiated once.

Test Plan:
- Reset value: rst_ni=0 mid-run → all ep_ack_o/ep_bus_o/ep_fips_o/fifo_lvl_o=0 immediately. After release, first word = 32'h0000_0001.
- Sequence: seed 1, NUM_EP=1, WORDS=1, req held, fips_i=1 → acks deliver 32'h0000_0001, 32'h8020_0003, 32'hC030_0002 with fips=1. First ack 2 cycles after enable.
- Packing: BUS_WIDTH=64, seed 1 → first ack bus = 64'h8020_0003_0000_0001, first ack 3 cycles after enable. fips_i low during the second word → ep_fips_o=0.
- Round-robin: NUM_EP=3, all reqs held, FIFO pre-filled → ack order 0,1,2,0. No endpoint acked in two consecutive cycles.
- Full/backpressure: no reqs, FIFO_DEPTH=4 → fifo_lvl_o saturates at 4 and LFSR freezes. Next delivered words resume contiguously, with no word skipped.
- Seed/disable: seed_i=0 loaded → LFSR=LFSR_SEED. enable_i dropped with lvl=3 → lvl=0 next cycle, pending req unacked until enable_i returns.
